// File: rtl/dac_spi_rx_if.sv
// SPI/LDAC pin bundle between the galvo DAC driver and the receive-side model.
// The driver side owns all four pins; the receiver only observes them.
interface dac_spi_rx_if;
    logic dac_CSN;
    logic dac_sclk;
    logic dac_mosi;
    logic dac_latch;

    modport master (output dac_CSN, output dac_sclk, output dac_mosi, output dac_latch);
    modport slave  (input  dac_CSN, input  dac_sclk, input  dac_mosi, input  dac_latch);
endinterface

// File: rtl/dac_spi_rx.sv
// Receive-side model of the dual galvo DAC.
// It deserializes SPI frames into per-channel input registers and
// transfers them to x_out/y_out on LDAC.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// DISARMED | after reset; waits for synced CSN high so a truncated frame is dropped
// IDLE     | between frames; a CSN fall clears the shifter and starts a frame
// SHIFT    | shifting mosi on each sclk rise; a CSN rise ends the frame
// COMMIT   | one cycle; load the input register on a 16-bit count, else report error
module dac_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    dac_spi_rx_if.slave       spi,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic [1:0]        chan_on,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              update
);

    localparam int FRAME_W = DATA_W + 4;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        IDLE     = 2'd1,
        SHIFT    = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] latch_sync;
    logic csn_d;
    logic sclk_d;
    logic latch_d;

    logic csn_s;
    logic sclk_s;
    logic mosi_s;
    logic latch_s;
    logic sclk_rise;
    logic csn_fall;
    logic csn_rise;
    logic latch_fall;

    logic [FRAME_W-1:0] shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  x_in;
    logic [DATA_W-1:0]  y_in;
    logic               xfer_req;

    // Pin synchronizers plus one history flop per edge-detected pin.
    // Everything resets to 0 so a CSN held low across reset looks asserted
    // and keeps the FSM disarmed until it really rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn_sync   <= '0;
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            latch_sync <= '0;
            csn_d      <= 1'b0;
            sclk_d     <= 1'b0;
            latch_d    <= 1'b0;
        end else begin
            csn_sync   <= {csn_sync[SYNC_STAGES-2:0],   spi.dac_CSN};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0],  spi.dac_sclk};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0],  spi.dac_mosi};
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], spi.dac_latch};
            csn_d      <= csn_sync[SYNC_STAGES-1];
            sclk_d     <= sclk_sync[SYNC_STAGES-1];
            latch_d    <= latch_sync[SYNC_STAGES-1];
        end
    end

    // Synced levels and edge strobes.
    always_comb begin
        csn_s      = csn_sync[SYNC_STAGES-1];
        sclk_s     = sclk_sync[SYNC_STAGES-1];
        mosi_s     = mosi_sync[SYNC_STAGES-1];
        latch_s    = latch_sync[SYNC_STAGES-1];
        sclk_rise  = sclk_s & ~sclk_d;
        csn_fall   = ~csn_s & csn_d;
        csn_rise   = csn_s & ~csn_d;
        latch_fall = ~latch_s & latch_d;
    end

    // Frame FSM, input registers and output transfer. A transfer request is
    // registered one cycle before the load, so a latch fall seen during COMMIT
    // picks up the just-committed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DISARMED;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            x_in        <= '0;
            y_in        <= '0;
            chan_on     <= 2'b00;
            x_out       <= '0;
            y_out       <= '0;
            xfer_req    <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            update      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            update      <= 1'b0;
            xfer_req    <= latch_fall;

            if (xfer_req) begin
                x_out  <= x_in;
                y_out  <= y_in;
                update <= 1'b1;
            end

            case (state)
                DISARMED: begin
                    if (csn_s) state <= IDLE;
                end
                IDLE: begin
                    if (csn_fall) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (csn_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise && !csn_s) begin
                        shift_reg <= {shift_reg[FRAME_W-2:0], mosi_s};
                        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    if (bit_cnt == CNT_FULL) begin
                        if (shift_reg[FRAME_W-1]) begin
                            y_in       <= shift_reg[DATA_W-1:0];
                            chan_on[1] <= shift_reg[DATA_W];
                        end else begin
                            x_in       <= shift_reg[DATA_W-1:0];
                            chan_on[0] <= shift_reg[DATA_W];
                        end
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    // LDAC tied low: every commit flows straight to the outputs.
                    if (!latch_s) xfer_req <= 1'b1;
                    state <= IDLE;
                end
                default: state <= DISARMED;
            endcase
        end
    end

endmodule
